// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default frame/oversampling parameters.
package uart_pkg;

  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_SAMPLE_RATE = 16;
  localparam int MID_SAMPLE      = DEF_SAMPLE_RATE / 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int mid_sample(input int sample_rate);
    return sample_rate / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte port of the UART receiver: valid/ready handshake plus per-byte error flags.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 framing_error;
  logic                 parity_error;

  modport master (output data, output valid, output framing_error, output parity_error, input ready);
  modport slave  (input data, input valid, input framing_error, input parity_error, output ready);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to RESET_VAL (all ones = idle line).
module uart_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_p0 <= RESET_VAL;
      q       <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB-first frame, valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SAMPLE_RATE = DEF_SAMPLE_RATE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       tick,
  output logic       start_rx,
  output logic       overrun,
  output logic       busy,
  uart_rx_if.master  rx_port
);

  localparam int CNT_W = $clog2(SAMPLE_RATE) + 1;
  localparam int IDX_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(mid_sample(SAMPLE_RATE) - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SAMPLE_RATE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_p0;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 fe_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 pe_r;
`endif

  uart_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign busy                  = (state != RX_IDLE);
  assign rx_port.data          = data_r;
  assign rx_port.valid         = valid_r;
  assign rx_port.framing_error = fe_r;
`ifdef UART_RX_PARITY_EN
  assign rx_port.parity_error  = pe_r;
`else
  assign rx_port.parity_error  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift_p0 <= '0;
      start_rx <= 1'b0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      fe_r     <= 1'b0;
      overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
      pe_r     <= 1'b0;
`endif
    end else begin
      start_rx <= 1'b0;
      // A byte completing below overrides this release in the same cycle.
      if (valid_r && rx_port.ready) valid_r <= 1'b0;

      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            start_rx <= 1'b1;
            tick_cnt <= '0;
            state    <= RX_START;
          end
        end

        RX_START: begin
          if (tick) begin
            if (tick_cnt == MID_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        RX_DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              shift_p0 <= {rx_s, shift_p0[DATA_BITS-1:1]};
              if (bit_idx == LAST_BIT) begin
                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= RX_PARITY;
`else
                state   <= RX_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
`endif

        RX_STOP: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              // Output slot is free if empty or being drained this cycle.
              if (!valid_r || rx_port.ready) begin
                data_r  <= shift_p0;
                valid_r <= 1'b1;
                fe_r    <= !rx_s;
`ifdef UART_RX_PARITY_EN
                pe_r    <= ^{shift_p0, par_bit};
`endif
              end else begin
                overrun <= 1'b1;
              end
              state <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        RX_WAIT_HIGH: begin
          // Break condition: hold off until the line is idle again.
          if (rx_s) begin
            tick_cnt <= '0;
            state    <= RX_IDLE;
          end
        end

        default: begin
          tick_cnt <= '0;
          state    <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, corner-case sequences and random frames vs. a frame model.
module tb_uart_rx;

  localparam int TP  = 4;
  localparam int SR  = 16;
  localparam int BIT = TP * SR;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Ticks from start_rx to the stop-bit sample: half a bit, then one full bit per remaining frame bit.
  localparam int STOP_TICK = SR / 2 + SR * (8 + PAR + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic tick;
  logic start_rx;
  logic overrun;
  logic busy;
  int   tcnt = 0;

  int errors = 0;
  int checks = 0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .SAMPLE_RATE(SR)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .tick     (tick),
    .start_rx (start_rx),
    .overrun  (overrun),
    .busy     (busy),
    .rx_port  (bus)
  );

  always #5 clock = ~clock;

  // Baud generator model: one tick every TP clocks, re-phased by start_rx.
  always @(posedge clock) begin
    if (reset || start_rx || tcnt == TP - 1) tcnt <= 0;
    else                                     tcnt <= tcnt + 1;
  end
  assign tick = (tcnt == TP - 1) && !start_rx;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  function automatic exp_t model(input logic [7:0] d, input logic pbit, input logic stop);
    exp_t e;
    int   ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    e.d  = d;
    e.fe = !stop;
    e.pe = (PAR != 0) && (((ones + int'(pbit)) % 2) == 1);
    return e;
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    rx = 1'b0;
    clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clk(BIT);
    end
    if (PAR != 0) begin
      rx = pbit;
      clk(BIT);
    end
    rx = stop;
    clk(BIT);
  endtask

  task automatic expect_byte(input string nm, input exp_t e);
    int n = 0;
    while (!bus.valid && n < 4 * BIT) begin
      clk(1);
      n++;
    end
    chk({nm, " valid"}, 32'(bus.valid), 32'(1));
    chk({nm, " data"},  32'(bus.data),  32'(e.d));
    chk({nm, " fe"},    32'(bus.framing_error), 32'(e.fe));
    chk({nm, " pe"},    32'(bus.parity_error),  32'(e.pe));
  endtask

  task automatic consume(input string nm);
    bus.ready = 1'b1;
    clk(1);
    bus.ready = 1'b0;
    chk({nm, " drop"}, 32'(bus.valid), 32'(0));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " start_rx"}, 32'(start_rx), 32'(0));
    chk({nm, " data"},     32'(bus.data), 32'(0));
    chk({nm, " valid"},    32'(bus.valid), 32'(0));
    chk({nm, " fe"},       32'(bus.framing_error), 32'(0));
    chk({nm, " pe"},       32'(bus.parity_error), 32'(0));
    chk({nm, " overrun"},  32'(overrun), 32'(0));
    chk({nm, " busy"},     32'(busy), 32'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    exp_t e;
    int   sp;

    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 8'h5A, 1'b1};

    bus.ready = 1'b0;
    clk(3);
    reset = 1'b0;
    clk(1);
    check_all_zero("reset");

    // Table vectors
    for (int v = 0; v < 4; v++) begin
      send_frame(tbl[v].d, tbl[v].stop, even_par(tbl[v].d));
      rx = 1'b1;
      clk(4);
      e.d  = tbl[v].exp_d;
      e.fe = tbl[v].exp_fe;
      e.pe = 1'b0;
      expect_byte($sformatf("vec%0d", v), e);
      consume($sformatf("vec%0d", v));
      clk(10);
    end

    // Short low glitch: one start pulse, false start, no byte
    sp = 0;
    rx = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 20) rx = 1'b1;
      clk(1);
      if (start_rx) sp++;
    end
    chk("glitch start pulses", 32'(sp), 32'(1));
    chk("glitch busy", 32'(busy), 32'(0));
    chk("glitch valid", 32'(bus.valid), 32'(0));

    // Break: stop low, line held low three bits
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    e = model(8'h3C, even_par(8'h3C), 1'b0);
    expect_byte("break", e);
    consume("break");
    sp = 0;
    for (int i = 0; i < 3 * BIT; i++) begin
      clk(1);
      if (start_rx) sp++;
    end
    chk("break no restart", 32'(sp), 32'(0));
    chk("break busy held", 32'(busy), 32'(1));
    rx = 1'b1;
    clk(10);
    chk("break released", 32'(busy), 32'(0));
    send_frame(8'h55, 1'b1, even_par(8'h55));
    expect_byte("after break", model(8'h55, even_par(8'h55), 1'b1));
    consume("after break");
    clk(10);

    // Overrun: two frames with ready low
    send_frame(8'h11, 1'b1, even_par(8'h11));
    send_frame(8'h22, 1'b1, even_par(8'h22));
    clk(4);
    chk("ovr valid", 32'(bus.valid), 32'(1));
    chk("ovr data kept", 32'(bus.data), 32'(8'h11));
    chk("ovr flag", 32'(overrun), 32'(1));

    // Third frame: ready raised exactly in the completing cycle
    fork
      send_frame(8'h33, 1'b1, even_par(8'h33));
      begin
        int n  = 0;
        int to = 0;
        while (!start_rx && to < 2 * BIT) begin
          clk(1);
          to++;
        end
        chk("ovr3 start seen", 32'(start_rx), 32'(1));
        to = 0;
        while (n < STOP_TICK && to < 20 * BIT) begin
          clk(1);
          to++;
          if (tick) n++;
        end
        chk("ovr3 stop tick reached", 32'(n), 32'(STOP_TICK));
        chk("ovr3 old byte before", 32'(bus.data), 32'(8'h11));
        bus.ready = 1'b1;
        clk(1);
        bus.ready = 1'b0;
        chk("ovr3 valid held", 32'(bus.valid), 32'(1));
        chk("ovr3 data new", 32'(bus.data), 32'(8'h33));
        chk("ovr3 overrun sticky", 32'(overrun), 32'(1));
      end
    join
    clk(10);

    // Parity checks
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    expect_byte("par good", '{8'h07, 1'b0, 1'b0});
    consume("par good");
    clk(10);
    send_frame(8'h07, 1'b1, 1'b0);
    expect_byte("par bad", '{8'h07, 1'b0, 1'b1});
    consume("par bad");
    clk(10);
`endif

    // Reset in the middle of DATA; byte 0x33 is still pending and overrun is set
    fork
      send_frame(8'hFF, 1'b1, even_par(8'hFF));
      begin
        clk(3 * BIT);
        chk("mid reset busy before", 32'(busy), 32'(1));
        reset = 1'b1;
        clk(1);
        reset = 1'b0;
        check_all_zero("mid reset");
      end
    join
    clk(10);
    send_frame(8'h81, 1'b1, even_par(8'h81));
    expect_byte("post reset", model(8'h81, even_par(8'h81), 1'b1));
    consume("post reset");
    clk(10);

    // Random frames against the model
    for (int r = 0; r < 8; r++) begin
      logic [7:0] d;
      logic       pb;
      logic       st;
      d  = 8'($urandom_range(0, 255));
      pb = even_par(d) ^ 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) != 0);
      send_frame(d, st, pb);
      rx = 1'b1;
      clk(4);
      expect_byte($sformatf("rand%0d", r), model(d, pb, st));
      clk($urandom_range(0, 20));
      consume($sformatf("rand%0d", r));
      clk(10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. It oversamples the `rx` line using the `tick` pulse from the baud rate generator, and pulses `start_rx` on each start-bit edge so the generator re-phases its tick counter. It recovers an LSB-first frame (start, data, optional parity, stop) and presents the byte on a valid/ready port to the downstream command logic.

## Interface
- `DATA_BITS`, 8: data bits per frame (5–9)
- `SAMPLE_RATE`, 16: ticks per bit period; must match the generator's `SAMPLE_RATE`
- `clock` input 1: system clock
- `reset` input 1: synchronous, active-high reset
- `rx` input 1: asynchronous serial line, idle high
- `tick` input 1: single-cycle oversample strobe from the baud rate generator
- `start_rx` output 1: single-cycle pulse to the generator on start-edge detection
- `data` output DATA_BITS: received byte, stable while `valid`
- `valid` output 1: byte available
- `ready` input 1: consumer accepts the byte when `valid && ready`
- `framing_error` output 1: stop bit sampled low for the byte in `data`
- `parity_error` output 1: parity mismatch for the byte in `data`
- `overrun` output 1: sticky; a completed byte was dropped; cleared only by `reset`
- `busy` output 1: high in every state except IDLE

## Operation
- `rx` passes through a two-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when `rx_s == 0`, pulse `start_rx` for 1 cycle, clear the tick counter and go to START.
- START: count ticks; on tick `SAMPLE_RATE/2` sample `rx_s`.
  - 1 → false start, go to IDLE with no output.
  - 0 → clear counter, go to DATA.
- DATA: on every `SAMPLE_RATE`th tick, shift `rx_s` into bit `bit_idx`, LSB first.
  - After `DATA_BITS` bits, go to PARITY (if compiled in) or STOP.
- PARITY: sample after `SAMPLE_RATE` ticks; compare against even parity of the data bits.
- STOP: sample after `SAMPLE_RATE` ticks (the stop-bit middle).
  - Load `data` and error flags; set `valid`.
  - `rx_s == 1` → go to IDLE. `rx_s == 0` → go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s == 1`, then go to IDLE. This stops a break condition from retriggering the receiver.
- Output port:
  - `valid && ready` clears `valid` on the next edge.
  - A byte completes while `valid && !ready` → the old byte is kept, the new byte is dropped, `overrun` is set.
  - A byte completes in the same cycle as `valid && ready` → the new byte loads, `valid` stays 1, no overrun.
- Tick counter is `$clog2(SAMPLE_RATE)+1` bits; `bit_idx` is `$clog2(DATA_BITS)+1` bits. Counters count only on `tick` and clear on every state transition.

## Timing
- Reset values: `start_rx` 0, `data` 0, `valid` 0, `framing_error` 0, `parity_error` 0, `overrun` 0, `busy` 0; FSM in IDLE.
- Reset mid-frame aborts the frame with no output, on the same edge.
- `rx` edge to `start_rx` pulse: 3 cycles (2 synchronizer + 1 FSM).
- `valid` rises 1 cycle after the stop-bit sample tick.
- Error flags change only when `data` loads.
- `start_rx` never asserts outside the IDLE→START transition.
- `tick` is ignored in IDLE and WAIT_HIGH.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present; frame is start + DATA_BITS + even parity + stop.
  - `parity_error` is high when the count of ones across data plus parity bit is odd.
- Not defined:
  - PARITY state is removed; frame is start + DATA_BITS + stop.
  - `parity_error` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `rx_state_t`
  - `SAMPLE_RATE` default and `MID_SAMPLE = SAMPLE_RATE/2`
  - default `DATA_BITS`
  - The transmitter imports the same package.
- Sub-module `uart_sync`: parameterized two-flop synchronizer with reset value 1 (line idle).

## Test plan
Bench instantiates `baud_rate_generator` with CLK_HZ=25000000, BAUD_RATE=9600, wired to `start_rx`/`tick`. One bit is 16×163 = 2608 clocks.
- Frame 0xA5 with stop high → `data`=0xA5 and `valid`=1 about 9.5 bits after the start edge; `framing_error`=0. `ready`=1 drops `valid` on the next cycle.
- Low glitch of 1000 clocks on `rx` → `start_rx` pulses once, FSM returns to IDLE, `valid` stays 0.
- Frame 0x3C with stop bit low, then `rx` held low for 3 bits → `data`=0x3C, `framing_error`=1. No new start until `rx` returns high; the next frame 0x55 is received cleanly.
- Frames 0x11 then 0x22 back-to-back with `ready`=0 → `data`=0x11, `overrun`=1. Raise `ready` in the cycle the third frame 0x33 completes → `data`=0x33, `valid` stays 1.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `parity_error`=0; with parity bit 0 → `parity_error`=1.
- Assert `reset` during DATA of frame 0xFF → all outputs 0 on the next cycle. A following frame 0x81 is received correctly.
